// File: rtl/nts_key_pkg.sv
// nts_key_pkg: shared widths, FSM state type and result record for the
// NTS key-fetch requester and its single-entry cache.
package nts_key_pkg;

  localparam int KEY_ID_W = 32;
  localparam int KEY_W    = 256;

  // Wide enough for the largest legal timeout (65535 cycles).
  localparam int CNT_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_REQ    = 2'd1,
    ST_ACKLOW = 2'd2
  } key_fetch_state_t;

  typedef struct packed {
    logic             ok;
    logic [KEY_W-1:0] key;
  } fetch_result_t;

  // Result reported for a timed-out lookup, and the value cleared on a new command.
  function automatic fetch_result_t empty_result();
    fetch_result_t r;
    r.ok  = 1'b0;
    r.key = '0;
    return r;
  endfunction

  // Result reported for a successful lookup with the given key.
  function automatic fetch_result_t good_result(input logic [KEY_W-1:0] k);
    fetch_result_t r;
    r.ok  = 1'b1;
    r.key = k;
    return r;
  endfunction

endpackage

// File: rtl/nts_key_cache.sv
// nts_key_cache: single-entry last-key cache. Holds one (ID, key) pair with
// a valid bit; a flush always beats a simultaneous load so that a key the
// host has just invalidated can never survive in the cache.
module nts_key_cache
  import nts_key_pkg::*;
(
  input  logic                clk156,
  input  logic                sys_reset,
  input  logic                load,
  input  logic [KEY_ID_W-1:0] load_id,
  input  logic [KEY_W-1:0]    load_key,
  input  logic                flush,
  input  logic [KEY_ID_W-1:0] lookup_id,
  output logic                hit,
  output logic [KEY_W-1:0]    cached_key
);

  logic                valid;
  logic [KEY_ID_W-1:0] entry_id;
  logic [KEY_W-1:0]    entry_key;

  // Entry register: flush clears valid first, otherwise a load replaces the entry.
  always_ff @(posedge clk156) begin
    if (sys_reset) begin
      valid     <= 1'b0;
      entry_id  <= '0;
      entry_key <= '0;
    end else if (flush) begin
      valid <= 1'b0;
    end else if (load) begin
      valid     <= 1'b1;
      entry_id  <= load_id;
      entry_key <= load_key;
    end
  end

  assign hit        = valid && (entry_id == lookup_id);
  assign cached_key = entry_key;

endmodule

// File: rtl/nts_key_fetch.sv
// nts_key_fetch: requester side of the key-memory lookup handshake.
// Accepts a lookup command in IDLE, runs a 4-phase key_req/key_ack cycle
// toward the key memory with a timeout, and reports done/ok/key.
// Define NTS_KEY_FETCH_CACHE_EN to include the single-entry last-key cache;
// without it every command takes the full key-memory round trip and
// key_flush has no effect.
module nts_key_fetch
  import nts_key_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1024
)
(
  input  logic                clk156,
  input  logic                sys_reset,
  input  logic                fetch_req,
  input  logic [KEY_ID_W-1:0] fetch_id,
  output logic                fetch_ready,
  output logic                fetch_done,
  output logic                fetch_ok,
  output logic [KEY_W-1:0]    fetch_key,
  input  logic                key_flush,
  output logic                key_req,
  output logic [KEY_ID_W-1:0] key_id,
  input  logic                key_ack,
  input  logic [KEY_W-1:0]    key
);

  // Count value on the last REQ cycle before giving up on the key memory.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  key_fetch_state_t    state, state_n;
  logic [CNT_W-1:0]    cnt, cnt_n;
  logic                key_req_q, key_req_n;
  logic [KEY_ID_W-1:0] key_id_q, key_id_n;
  logic                done_q, done_n;
  fetch_result_t       result_q, result_n;

  logic                cache_load;
  logic                cache_hit;
  logic [KEY_W-1:0]    cache_key;

`ifdef NTS_KEY_FETCH_CACHE_EN
  nts_key_cache u_cache (
    .clk156     (clk156),
    .sys_reset  (sys_reset),
    .load       (cache_load),
    .load_id    (key_id_q),
    .load_key   (key),
    .flush      (key_flush),
    .lookup_id  (fetch_id),
    .hit        (cache_hit),
    .cached_key (cache_key)
  );
`else
  // Without the cache every lookup misses and a flush has nothing to clear.
  logic unused_cache_inputs;
  assign unused_cache_inputs = key_flush ^ cache_load;
  assign cache_hit = 1'b0;
  assign cache_key = '0;
`endif

  // Next-state and next-output logic for the request FSM.
  always_comb begin
    state_n    = state;
    cnt_n      = cnt;
    key_req_n  = key_req_q;
    key_id_n   = key_id_q;
    done_n     = 1'b0;
    result_n   = result_q;
    cache_load = 1'b0;

    case (state)
      ST_IDLE: begin
        if (fetch_req) begin
          if (cache_hit) begin
            done_n   = 1'b1;
            result_n = good_result(cache_key);
          end else begin
            state_n   = ST_REQ;
            key_req_n = 1'b1;
            key_id_n  = fetch_id;
            cnt_n     = '0;
            result_n  = empty_result();
          end
        end
      end

      ST_REQ: begin
        // An ack on the timeout cycle still counts, so it is tested first.
        if (key_ack) begin
          state_n    = ST_ACKLOW;
          key_req_n  = 1'b0;
          done_n     = 1'b1;
          result_n   = good_result(key);
          cache_load = 1'b1;
        end else if (cnt == CNT_LAST) begin
          state_n   = ST_ACKLOW;
          key_req_n = 1'b0;
          done_n    = 1'b1;
          result_n  = empty_result();
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end

      ST_ACKLOW: begin
        // A late ack after a timeout is swallowed here until it drops.
        if (!key_ack) begin
          state_n = ST_IDLE;
        end
      end

      default: begin
        state_n   = ST_IDLE;
        key_req_n = 1'b0;
      end
    endcase
  end

  // State and output registers; reset returns every output to idle values.
  always_ff @(posedge clk156) begin
    if (sys_reset) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      key_req_q <= 1'b0;
      key_id_q  <= '0;
      done_q    <= 1'b0;
      result_q  <= empty_result();
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      key_req_q <= key_req_n;
      key_id_q  <= key_id_n;
      done_q    <= done_n;
      result_q  <= result_n;
    end
  end

  assign fetch_ready = (state == ST_IDLE);
  assign fetch_done  = done_q;
  assign fetch_ok    = result_q.ok;
  assign fetch_key   = result_q.key;
  assign key_req     = key_req_q;
  assign key_id      = key_id_q;

endmodule
